// File: rtl/uart_rx_cmd_decoder_if.sv
// Decoder-facing bundle: RX byte stream in, RF/ALU strobes out, response bytes out on valid/ready.
// slave = decoder side; master = surrounding system (UART RX/TX, register file, ALU).
interface uart_rx_cmd_decoder_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_par_err;
  logic              rx_stp_err;
  logic [ADDR_W-1:0] rf_addr;
  logic [7:0]        rf_wr_data;
  logic              rf_wr_en;
  logic              rf_rd_en;
  logic [7:0]        rf_rd_data;
  logic              rf_rd_valid;
  logic [3:0]        alu_fun;
  logic              alu_en;
  logic [15:0]       alu_out;
  logic              alu_out_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              frame_err;
  logic              overrun;

  modport slave (
    input  rx_data, rx_valid, rx_par_err, rx_stp_err,
    input  rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
    output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en,
    output tx_data, tx_valid, busy, frame_err, overrun
  );

  modport master (
    output rx_data, rx_valid, rx_par_err, rx_stp_err,
    output rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
    input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en,
    input  tx_data, tx_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_cmd_decoder.sv
// Decodes RX command frames into RF writes/reads and ALU ops; all strobes one cycle after the byte.
// Response bytes held on tx_valid until tx_ready; bytes arriving while waiting/sending are dropped.
module uart_rx_cmd_decoder #(
  parameter int ADDR_W      = 4,
  parameter int TO_W        = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_cmd_decoder_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A,
    ALU_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI
  } state_t;

  localparam logic [7:0]      CMD_WR   = 8'hAA;
  localparam logic [7:0]      CMD_RD   = 8'hBB;
  localparam logic [7:0]      CMD_ALU3 = 8'hCC;
  localparam logic [7:0]      CMD_ALU1 = 8'hDD;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX   = '1;

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [7:0]        rf_wr_data_q;
  logic              rf_wr_en_q;
  logic              rf_rd_en_q;
  logic [3:0]        alu_fun_q;
  logic              alu_en_q;
  logic [7:0]        alu_hi_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              frame_err_q;
  logic              overrun_q;

  logic rx_bad;
  logic byte_await;
  logic in_wait;
  logic timed_out;
  logic tx_fire;

  assign rx_bad     = bus.rx_valid & (bus.rx_par_err | bus.rx_stp_err);
  assign byte_await = state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};
  assign in_wait    = state inside {RD_WAIT, ALU_WAIT};
  assign timed_out  = (byte_await | in_wait) && (to_cnt >= TO_LAST);
  assign tx_fire    = tx_valid_q & bus.tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_fun_q    <= '0;
      alu_en_q     <= 1'b0;
      alu_hi_q     <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rf_wr_en_q  <= 1'b0;
      rf_rd_en_q  <= 1'b0;
      alu_en_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Saturating count while waiting; every branch that moves state or takes a byte clears it.
      if ((byte_await | in_wait) && (to_cnt != TO_MAX))
        to_cnt <= to_cnt + TO_W'(1);

      unique case (state)
        IDLE: begin
          to_cnt <= '0;
          if (rx_bad) begin
            frame_err_q <= 1'b1;
          end else if (bus.rx_valid) begin
            unique case (bus.rx_data)
              CMD_WR:   state <= WR_ADDR;
              CMD_RD:   state <= RD_ADDR;
              CMD_ALU3: state <= ALU_A;
              CMD_ALU1: state <= ALU_FUN;
              default:  frame_err_q <= 1'b1;
            endcase
          end
        end

        WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN: begin
          if (rx_bad || (!bus.rx_valid && timed_out)) begin
            frame_err_q <= 1'b1;
            state       <= IDLE;
            to_cnt      <= '0;
          end else if (bus.rx_valid) begin
            to_cnt <= '0;
            unique case (state)
              WR_ADDR: begin
                rf_addr_q <= bus.rx_data[ADDR_W-1:0];
                state     <= WR_DATA;
              end
              WR_DATA: begin
                rf_wr_data_q <= bus.rx_data;
                rf_wr_en_q   <= 1'b1;
                state        <= IDLE;
              end
              RD_ADDR: begin
                rf_addr_q  <= bus.rx_data[ADDR_W-1:0];
                rf_rd_en_q <= 1'b1;
                state      <= RD_WAIT;
              end
              ALU_A: begin
                rf_addr_q    <= ADDR_W'(0);
                rf_wr_data_q <= bus.rx_data;
                rf_wr_en_q   <= 1'b1;
                state        <= ALU_B;
              end
              ALU_B: begin
                rf_addr_q    <= ADDR_W'(1);
                rf_wr_data_q <= bus.rx_data;
                rf_wr_en_q   <= 1'b1;
                state        <= ALU_FUN;
              end
              default: begin
                alu_fun_q <= bus.rx_data[3:0];
                alu_en_q  <= 1'b1;
                state     <= ALU_WAIT;
              end
            endcase
          end
        end

        RD_WAIT: begin
          overrun_q <= bus.rx_valid;
          if (bus.rf_rd_valid) begin
            tx_data_q  <= bus.rf_rd_data;
            tx_valid_q <= 1'b1;
            state      <= TX_RD;
            to_cnt     <= '0;
          end else if (timed_out) begin
            frame_err_q <= 1'b1;
            state       <= IDLE;
            to_cnt      <= '0;
          end
        end

        ALU_WAIT: begin
          overrun_q <= bus.rx_valid;
          if (bus.alu_out_valid) begin
            tx_data_q  <= bus.alu_out[7:0];
            alu_hi_q   <= bus.alu_out[15:8];
            tx_valid_q <= 1'b1;
            state      <= TX_LO;
            to_cnt     <= '0;
          end else if (timed_out) begin
            frame_err_q <= 1'b1;
            state       <= IDLE;
            to_cnt      <= '0;
          end
        end

        // No timeout here: the TX side may stall indefinitely.
        TX_RD, TX_HI: begin
          overrun_q <= bus.rx_valid;
          to_cnt    <= '0;
          if (tx_fire) begin
            tx_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end

        TX_LO: begin
          overrun_q <= bus.rx_valid;
          to_cnt    <= '0;
          if (tx_fire) begin
            tx_data_q <= alu_hi_q;
            state     <= TX_HI;
          end
        end

        default: begin
          state  <= IDLE;
          to_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;
  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_rd_en   = rf_rd_en_q;
  assign bus.alu_fun    = alu_fun_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: output events are scoreboarded against expectations queued with stimulus.
module tb_uart_rx_cmd_decoder;
  localparam int ADDR_W      = 4;
  localparam int TO_W        = 16;
  localparam int TIMEOUT_CYC = 64;

  localparam logic [7:0] EV_WR  = 8'd1;
  localparam logic [7:0] EV_RD  = 8'd2;
  localparam logic [7:0] EV_ALU = 8'd3;
  localparam logic [7:0] EV_TX  = 8'd4;
  localparam logic [7:0] EV_FE  = 8'd5;
  localparam logic [7:0] EV_OV  = 8'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_cmd_decoder_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_cmd_decoder #(
    .ADDR_W(ADDR_W), .TO_W(TO_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [7:0] k, input logic [7:0] a, input logic [15:0] d);
    return {k, a, d};
  endfunction

  task automatic sb_pop(input string tag, input logic [31:0] got);
    check({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) check(tag, got, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      int n;
      n = int'(bus.rf_wr_en) + int'(bus.rf_rd_en) + int'(bus.alu_en);
      if (n > 0) check("strobe_excl", n, 1);
      if (bus.rf_wr_en) sb_pop("rf_wr", ev(EV_WR, 8'(bus.rf_addr), {8'h00, bus.rf_wr_data}));
      if (bus.rf_rd_en) sb_pop("rf_rd", ev(EV_RD, 8'(bus.rf_addr), 16'h0000));
      if (bus.alu_en)   sb_pop("alu_en", ev(EV_ALU, 8'(bus.alu_fun), 16'h0000));
      if (bus.tx_valid && bus.tx_ready) sb_pop("tx", ev(EV_TX, 8'h00, {8'h00, bus.tx_data}));
      if (bus.frame_err) sb_pop("frame_err", ev(EV_FE, 8'h00, 16'h0000));
      if (bus.overrun)   sb_pop("overrun", ev(EV_OV, 8'h00, 16'h0000));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic pe, input logic se);
    bus.rx_data    = b;
    bus.rx_valid   = 1'b1;
    bus.rx_par_err = pe;
    bus.rx_stp_err = se;
    tick(1);
    bus.rx_valid   = 1'b0;
    bus.rx_par_err = 1'b0;
    bus.rx_stp_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_par_err = 1'b0; bus.rx_stp_err = 1'b0;
    bus.rf_rd_data = 8'h00; bus.rf_rd_valid = 1'b0;
    bus.alu_out = 16'h0000; bus.alu_out_valid = 1'b0;
    bus.tx_ready = 1'b1;
    tick(3);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_rf_wr_en", bus.rf_wr_en, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_alu_fun", bus.alu_fun, 0);
    check("rst_rf_addr", bus.rf_addr, 0);
    rst = 1'b0;
    tick(2);

    // Register write
    exp_q.push_back(ev(EV_WR, 8'h05, 16'h003C));
    send(8'hAA, 1'b0, 1'b0);
    check("wr_busy_mid", bus.busy, 1);
    send(8'h05, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    check("wr_en_lat1", bus.rf_wr_en, 1);
    tick(1);
    check("wr_en_pulse", bus.rf_wr_en, 0);
    check("wr_busy_after", bus.busy, 0);

    // Register read with TX backpressure
    bus.tx_ready = 1'b0;
    exp_q.push_back(ev(EV_RD, 8'h07, 16'h0000));
    send(8'hBB, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    check("rd_en_lat1", bus.rf_rd_en, 1);
    tick(2);
    exp_q.push_back(ev(EV_TX, 8'h00, 16'h005A));
    bus.rf_rd_data = 8'h5A; bus.rf_rd_valid = 1'b1;
    tick(1);
    bus.rf_rd_valid = 1'b0; bus.rf_rd_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check("rd_tx_held", bus.tx_valid, 1);
      check("rd_tx_data", bus.tx_data, 8'h5A);
      tick(1);
    end
    bus.tx_ready = 1'b1;
    tick(1);
    check("rd_tx_done", bus.tx_valid, 0);
    check("rd_busy_after", bus.busy, 0);
    bus.rf_rd_data = 8'hEE; bus.rf_rd_valid = 1'b1;
    tick(1);
    bus.rf_rd_valid = 1'b0;
    tick(2);
    check("stray_rd_valid", bus.tx_valid, 0);

    // Three-operand ALU frame
    exp_q.push_back(ev(EV_WR, 8'h00, 16'h0012));
    exp_q.push_back(ev(EV_WR, 8'h01, 16'h0034));
    exp_q.push_back(ev(EV_ALU, 8'h01, 16'h0000));
    send(8'hCC, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    check("alu3_fun", bus.alu_fun, 4'h1);
    tick(3);
    check("alu3_wait_busy", bus.busy, 1);
    exp_q.push_back(ev(EV_TX, 8'h00, 16'h0034));
    exp_q.push_back(ev(EV_TX, 8'h00, 16'h0012));
    bus.alu_out = 16'h1234; bus.alu_out_valid = 1'b1;
    tick(1);
    bus.alu_out_valid = 1'b0;
    tick(3);
    check("alu3_busy_after", bus.busy, 0);
    check("alu3_fun_held", bus.alu_fun, 4'h1);

    // Parity error on the data byte of a write
    exp_q.push_back(ev(EV_FE, 8'h00, 16'h0000));
    send(8'hAA, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    check("perr_frame_err", bus.frame_err, 1);
    check("perr_no_wr", bus.rf_wr_en, 0);
    check("perr_idle", bus.busy, 0);
    tick(1);

    // Stop error on a command byte in IDLE
    exp_q.push_back(ev(EV_FE, 8'h00, 16'h0000));
    send(8'hAA, 1'b0, 1'b1);
    check("serr_idle", bus.busy, 0);
    tick(1);

    // Inter-byte timeout
    exp_q.push_back(ev(EV_FE, 8'h00, 16'h0000));
    send(8'hBB, 1'b0, 1'b0);
    tick(TIMEOUT_CYC - 1);
    check("to_not_early", bus.frame_err, 0);
    check("to_busy_before", bus.busy, 1);
    tick(1);
    check("to_frame_err", bus.frame_err, 1);
    check("to_idle", bus.busy, 0);
    tick(1);

    // Unknown command
    exp_q.push_back(ev(EV_FE, 8'h00, 16'h0000));
    send(8'h77, 1'b0, 1'b0);
    check("unk_frame_err", bus.frame_err, 1);
    check("unk_idle", bus.busy, 0);
    tick(1);

    // Timeout waiting for read data
    exp_q.push_back(ev(EV_RD, 8'h03, 16'h0000));
    exp_q.push_back(ev(EV_FE, 8'h00, 16'h0000));
    send(8'hBB, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    tick(TIMEOUT_CYC - 1);
    check("rdto_busy_before", bus.busy, 1);
    tick(1);
    check("rdto_frame_err", bus.frame_err, 1);
    check("rdto_idle", bus.busy, 0);
    tick(1);

    // Single-operand ALU, overrun, then reset mid-TX
    bus.tx_ready = 1'b0;
    exp_q.push_back(ev(EV_ALU, 8'h02, 16'h0000));
    send(8'hDD, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    check("alu1_en", bus.alu_en, 1);
    check("alu1_fun", bus.alu_fun, 4'h2);
    tick(1);
    exp_q.push_back(ev(EV_OV, 8'h00, 16'h0000));
    send(8'h55, 1'b0, 1'b0);
    check("ovr_pulse", bus.overrun, 1);
    check("ovr_busy", bus.busy, 1);
    bus.alu_out = 16'hBEEF; bus.alu_out_valid = 1'b1;
    tick(1);
    bus.alu_out_valid = 1'b0;
    check("txlo_valid", bus.tx_valid, 1);
    check("txlo_data", bus.tx_data, 8'hEF);
    tick(2);
    rst = 1'b1;
    #1;
    check("rst_mid_tx_valid", bus.tx_valid, 0);
    check("rst_mid_busy", bus.busy, 0);
    tick(1);
    rst = 1'b0;
    check("rst_mid_alu_fun", bus.alu_fun, 0);
    tick(2);
    check("post_rst_tx_valid", bus.tx_valid, 0);
    bus.tx_ready = 1'b1;
    tick(2);

    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
